// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and default constants for the memory bus arbiter
package soc_bus_pkg;

    typedef enum logic {
        OWNER_INSTR,
        OWNER_DATA
    } owner_e;

    typedef enum logic [1:0] {
        REGION_MEM,
        REGION_PER,
        REGION_NONE
    } region_e;

    typedef enum logic {
        IDLE,
        PER_WAIT
    } arb_state_e;

    localparam logic [31:0] MEM_START_DEFAULT = 32'h0000_0000;
    localparam logic [15:0] PER_BASE_DEFAULT  = 16'hFF00;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - core-side and target-side bus signals of the memory bus arbiter
interface mem_bus_arbiter_if;

    // instruction-fetch port
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    // load/store port
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    // single-port SRAM
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    // peripheral register window
    logic        per_req_o;
    logic        per_we_o;
    logic [15:0] per_addr_o;
    logic [31:0] per_wdata_o;
    logic        per_rvalid_i;
    logic [31:0] per_rdata_i;

    // arbiter side
    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output per_req_o, per_we_o, per_addr_o, per_wdata_o,
        input  per_rvalid_i, per_rdata_i
    );

    // core and target side
    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  per_req_o, per_we_o, per_addr_o, per_wdata_o,
        output per_rvalid_i, per_rdata_i
    );

endinterface

// File: rtl/mem_bus_arbiter_decode.sv
// rtl/mem_bus_arbiter_decode.sv - combinational address-to-region decoder
module bus_addr_decode
    import soc_bus_pkg::*;
#(
    parameter logic [31:0] MEM_START = MEM_START_DEFAULT,
    parameter int unsigned MEM_SIZE  = 262144,
    parameter logic [15:0] PER_BASE  = PER_BASE_DEFAULT
) (
    input  logic [31:0] i_addr,
    input  logic        i_is_data,
    output region_e     o_region
);

    localparam logic [31:0] MEM_MASK = ~(32'(MEM_SIZE) - 32'd1);

    // SRAM wins over the peripheral window; the window is reachable only from the data port
    always_comb begin
        o_region = REGION_NONE;
        if ((i_addr & MEM_MASK) == MEM_START) begin
            o_region = REGION_MEM;
        end else if (i_is_data && (i_addr[31:16] == PER_BASE)) begin
            o_region = REGION_PER;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares SRAM and peripheral window between fetch and data ports
module mem_bus_arbiter
    import soc_bus_pkg::*;
#(
    parameter logic [31:0] MEM_START   = MEM_START_DEFAULT,
    parameter int unsigned MEM_SIZE    = 262144,
    parameter logic [15:0] PER_BASE    = PER_BASE_DEFAULT,
    parameter int unsigned MAX_STREAK  = 4,
    parameter int unsigned PER_TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_bus_arbiter_if.slave   bus
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [7:0] TIMER_LAST = 8'(PER_TIMEOUT - 1);

    arb_state_e r_state, w_state_next;
    logic [3:0] r_streak, w_streak_next;
    logic [7:0] r_timer, w_timer_next;
    logic       r_resp_valid, w_resp_valid_next;
    owner_e     r_resp_owner, w_resp_owner_next;
    logic       r_resp_mem, w_resp_mem_next;

    region_e    w_instr_region;
    region_e    w_data_region;
    region_e    w_gnt_region;
    logic       w_gnt_instr;
    logic       w_gnt_data;
    logic       w_gnt_any;
    logic       w_per_req;
    logic       w_per_done;
    logic       w_per_timeout;
    logic       w_data_reg_resp;

    bus_addr_decode #(
        .MEM_START (MEM_START),
        .MEM_SIZE  (MEM_SIZE),
        .PER_BASE  (PER_BASE)
    ) u_decode_instr (
        .i_addr    (bus.instr_addr_i),
        .i_is_data (1'b0),
        .o_region  (w_instr_region)
    );

    bus_addr_decode #(
        .MEM_START (MEM_START),
        .MEM_SIZE  (MEM_SIZE),
        .PER_BASE  (PER_BASE)
    ) u_decode_data (
        .i_addr    (bus.data_addr_i),
        .i_is_data (1'b1),
        .o_region  (w_data_region)
    );

    // Data has priority unless fetch has already waited MAX_STREAK data grants
    always_comb begin
        w_gnt_data  = 1'b0;
        w_gnt_instr = 1'b0;
        if (!rst_i && (r_state == IDLE)) begin
            if (bus.data_req_i && (!bus.instr_req_i || (r_streak != STREAK_MAX))) begin
                w_gnt_data = 1'b1;
            end else if (bus.instr_req_i) begin
                w_gnt_instr = 1'b1;
            end
        end
        w_gnt_any     = w_gnt_instr || w_gnt_data;
        w_gnt_region  = w_gnt_data ? w_data_region : w_instr_region;
        w_per_req     = w_gnt_data && (w_data_region == REGION_PER);
        w_per_done    = !rst_i && (r_state == PER_WAIT) && bus.per_rvalid_i;
        w_per_timeout = !rst_i && (r_state == PER_WAIT) && !bus.per_rvalid_i
                        && (r_timer == TIMER_LAST);
    end

    // Target requests follow the granted port in the grant cycle
    always_comb begin
        bus.mem_req_o   = w_gnt_any && (w_gnt_region == REGION_MEM);
        bus.mem_we_o    = w_gnt_data && bus.data_we_i;
        bus.mem_be_o    = w_gnt_data ? bus.data_be_i : 4'hF;
        bus.mem_addr_o  = w_gnt_data ? bus.data_addr_i : bus.instr_addr_i;
        bus.mem_wdata_o = w_gnt_data ? bus.data_wdata_i : 32'h0;
        bus.per_req_o   = w_per_req;
        bus.per_we_o    = w_per_req && bus.data_we_i;
        bus.per_addr_o  = bus.data_addr_i[15:0];
        bus.per_wdata_o = bus.data_wdata_i;
        bus.instr_gnt_o = w_gnt_instr;
        bus.data_gnt_o  = w_gnt_data;
    end

    // Responses: registered for SRAM/unmapped, combinational for peripheral completion
    always_comb begin
        bus.instr_rvalid_o = r_resp_valid && (r_resp_owner == OWNER_INSTR);
        bus.instr_err_o    = bus.instr_rvalid_o && !r_resp_mem;
        bus.instr_rdata_o  = (bus.instr_rvalid_o && r_resp_mem) ? bus.mem_rdata_i : 32'h0;

        w_data_reg_resp    = r_resp_valid && (r_resp_owner == OWNER_DATA);
        bus.data_rvalid_o  = w_data_reg_resp || w_per_done || w_per_timeout;
        bus.data_err_o     = (w_data_reg_resp && !r_resp_mem) || w_per_timeout;
        if (w_per_done) begin
            bus.data_rdata_o = bus.per_rdata_i;
        end else if (w_data_reg_resp && r_resp_mem) begin
            bus.data_rdata_o = bus.mem_rdata_i;
        end else begin
            bus.data_rdata_o = 32'h0;
        end
    end

    // Next-state: FSM, timeout counter, pending response and fetch starvation streak
    always_comb begin
        w_state_next      = r_state;
        w_timer_next      = r_timer;
        w_streak_next     = r_streak;
        w_resp_valid_next = 1'b0;
        w_resp_owner_next = r_resp_owner;
        w_resp_mem_next   = r_resp_mem;

        case (r_state)
            IDLE: begin
                if (w_per_req) begin
                    w_state_next = PER_WAIT;
                    w_timer_next = 8'd0;
                end
            end
            PER_WAIT: begin
                if (w_per_done || w_per_timeout) begin
                    w_state_next = IDLE;
                end else begin
                    w_timer_next = r_timer + 8'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_gnt_any && (w_gnt_region != REGION_PER)) begin
            w_resp_valid_next = 1'b1;
            w_resp_owner_next = w_gnt_data ? OWNER_DATA : OWNER_INSTR;
            w_resp_mem_next   = (w_gnt_region == REGION_MEM);
        end

        if (!bus.instr_req_i || w_gnt_instr) begin
            w_streak_next = 4'd0;
        end else if (w_gnt_data && (r_streak != STREAK_MAX)) begin
            w_streak_next = r_streak + 4'd1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_streak     <= 4'd0;
            r_timer      <= 8'd0;
            r_resp_valid <= 1'b0;
            r_resp_owner <= OWNER_INSTR;
            r_resp_mem   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_streak     <= w_streak_next;
            r_timer      <= w_timer_next;
            r_resp_valid <= w_resp_valid_next;
            r_resp_owner <= w_resp_owner_next;
            r_resp_mem   <= w_resp_mem_next;
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port SRAM and the peripheral register window between the core's instruction-fetch and data ports.
- Decodes each address to one of three regions: SRAM, peripheral window, or unmapped.
- Grants at most one requester per cycle, using data-priority arbitration with a starvation guard for instruction fetch.
- Routes responses back to the granted port and generates access-fault errors, including a timeout on peripheral accesses.

Parameters:
- MEM_START, 32'h00000000, SRAM base address; must be aligned to MEM_SIZE.
- MEM_SIZE, 262144, SRAM size in bytes; must be a power of two.
- PER_BASE, 16'hFF00, value of addr[31:16] that selects the peripheral window.
- MAX_STREAK, 4, maximum consecutive data grants while instruction fetch is pending; range 1..15.
- PER_TIMEOUT, 16, cycles spent in PER_WAIT before a peripheral access faults; range 2..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  fetch address.
- instr_gnt_o  out  1  fetch grant; combinational.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch data.
- instr_err_o  out  1  fetch fault; qualified by instr_rvalid_o.
- data_req_i  in  1  load/store request.
- data_we_i  in  1  write enable.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  data address.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  data grant; combinational.
- data_rvalid_o  out  1  data response valid.
- data_rdata_o  out  32  read data.
- data_err_o  out  1  data fault; qualified by data_rvalid_o.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write.
- mem_be_o  out  4  SRAM byte enables.
- mem_addr_o  out  32  SRAM address.
- mem_wdata_o  out  32  SRAM write data.
- mem_rdata_i  in  32  SRAM read data; valid exactly 1 cycle after mem_req_o.
- per_req_o  out  1  peripheral request; single-cycle pulse.
- per_we_o  out  1  peripheral write.
- per_addr_o  out  16  peripheral offset, equal to addr[15:0].
- per_wdata_o  out  32  peripheral write data.
- per_rvalid_i  in  1  peripheral response; arrives 1 or more cycles after per_req_o.
- per_rdata_i  in  32  peripheral read data.

Behaviour:
- Reset (synchronous; rst_i high at a clock edge):
  - Next-state values: state=IDLE, streak=0, resp_valid=0, per timeout counter=0.
  - While rst_i is high, all gnt outputs and target request outputs (mem_req_o, per_req_o) are forced to 0.
  - A reset during PER_WAIT abandons the access; no response is issued.
- Address decode:
  - SRAM hit: (addr & ~(MEM_SIZE-1)) == MEM_START.
  - Peripheral hit: addr[31:16] == PER_BASE, and only on the data port.
  - A fetch from the peripheral window, or any other address, is unmapped.
- States: IDLE and PER_WAIT. Grants are issued only in IDLE.
- Arbitration in IDLE:
  - Only one requester active: it is granted.
  - Both active: data is granted, unless streak == MAX_STREAK, in which case instruction is granted.
- Streak counter:
  - Increments on each data grant while instr_req_i is high.
  - Clears on an instruction grant, or in any cycle where instr_req_i is low.
  - Saturates at MAX_STREAK.
- SRAM grant:
  - mem_req_o=1 in the grant cycle.
  - mem_we_o = data grant & data_we_i.
  - mem_be_o = data_be_i for data, 4'hF for fetch.
  - mem_addr_o / mem_wdata_o come from the granted port.
  - Next cycle: owner rvalid=1, rdata=mem_rdata_i, err=0.
- Unmapped grant:
  - No target request is issued.
  - Next cycle: owner rvalid=1, err=1, rdata=32'h0.
- Peripheral grant:
  - per_req_o=1 for exactly the grant cycle; next state is PER_WAIT with the counter cleared.
  - In PER_WAIT, if per_rvalid_i=1: data_rvalid_o=1 combinationally, data_rdata_o=per_rdata_i, err=0; next state IDLE.
  - If the counter reaches PER_TIMEOUT-1 with per_rvalid_i low: data_rvalid_o=1, err=1, rdata=0; next state IDLE.
  - per_rvalid_i is ignored outside PER_WAIT.
- Response rules:
  - At most one rvalid is asserted per cycle, and each grant produces exactly one response.
  - Unused rdata outputs are driven 0.
  - Back-to-back SRAM grants are allowed with throughput of 1 per cycle.
  - A grant is allowed in the cycle a registered response is delivered.

Decomposition:
- Package soc_bus_pkg holds:
  - owner_e {OWNER_INSTR, OWNER_DATA}.
  - region_e {REGION_MEM, REGION_PER, REGION_NONE}.
  - arb_state_e {IDLE, PER_WAIT}.
  - Default constants MEM_START_DEFAULT and PER_BASE_DEFAULT.
- One sub-module, bus_addr_decode: purely combinational. Inputs are addr and an is_data flag; output is region_e. It is instantiated twice, once per port.
- Arbitration, the FSM, the timeout counter and the response register stay in the top-level module.

Test Plan:
- Fetch 0x100 alone with SRAM word 0x00000013 → instr_gnt same cycle; next cycle instr_rvalid=1, rdata=0x13, err=0.
- Both ports request continuously with MAX_STREAK=4 → grant order is D,D,D,D,I,D,D,D,D,I; no cycle has two grants.
- Data read 0xFF000004 with per_rvalid after 3 cycles, per_rdata=0x1 → per_req one pulse; no grants for 3 cycles; data_rvalid=1, rdata=0x1.
- Data read 0xFF000000 with peripheral silent → data_rvalid=1, err=1 exactly PER_TIMEOUT cycles after grant; a late per_rvalid produces no response.
- Fetch 0xFF000000, then data write 0x80000000 → both granted and return err=1, rdata=0; mem_req and per_req stay 0.
- Assert rst_i in the second PER_WAIT cycle → no data_rvalid; state returns to IDLE; the first post-reset fetch completes normally.
